// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU.
//   OP_*     : 3-bit operation encodings
//   state_t  : control FSM states
//   is_arith : true for the ops that produce carry/overflow flags (ADD, SUB)
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// One D-bit digit slice of the serial ALU, purely combinational.
//   op    in  3  operation select
//   a     in  D  operand A digit
//   b     in  D  operand B digit (inverted internally for SUB)
//   ci    in  1  carry into bit 0 of this digit
//   r     out D  result digit
//   co    out 1  carry out of bit D-1
//   c_msb out 1  carry into bit D-1 (used for signed overflow on the last digit)
module alu_digit
    import alu_pkg::*;
#(
    parameter int D = 4
) (
    input  logic [2:0]   op,
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         ci,
    output logic [D-1:0] r,
    output logic         co,
    output logic         c_msb
);

    logic [D-1:0] bx;
    logic [D-1:0] sum;
    logic [D:0]   c;

    // SUB is A + ~B + 1; the +1 arrives as the seeded carry on digit 0.
    assign bx   = (op == OP_SUB) ? ~b : b;
    assign c[0] = ci;

    for (genvar i = 0; i < D; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign co    = c[D];
    assign c_msb = c[D - 1];

    always_comb begin
        // NOTE: r gets a value on every path (default first) so no latch is inferred.
        r = sum;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            default: r = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: W-bit operands processed D bits per clock, LSB digit first.
// Operands enter through a valid/ready handshake; the result and flags are held
// in DONE until the consumer accepts them.
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake for op, i0, i1, cin
//   op, i0, i1, cin     operation, operands, carry-in (ADD only)
//   out_valid/out_ready output handshake for o and flags
//   o, cout, zero, ovf  result, carry-out, result==0, signed overflow
module alu_serial
    import alu_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] o,
    output logic         cout,
    output logic         zero,
    output logic         ovf
);

    localparam int NDIG = W / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((D < 1) || (W % D != 0)) begin : g_bad_param
        $error("alu_serial: D must be >= 1 and divide W");
    end

    state_t         state, state_nxt;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic           carry_q;
    logic [CW-1:0]  cnt;

    logic [D-1:0]   dig_a, dig_b, dig_r;
    logic           dig_co, dig_cmsb;
    logic [W-1:0]   o_nxt;
    logic           last;
    logic           accept;

    assign dig_a  = a_q[int'(cnt) * D +: D];
    assign dig_b  = b_q[int'(cnt) * D +: D];
    assign last   = (cnt == CW'(NDIG - 1));
    assign accept = in_valid && in_ready;

    alu_digit #(.D(D)) u_digit (
        .op    (op_q),
        .a     (dig_a),
        .b     (dig_b),
        .ci    (carry_q),
        .r     (dig_r),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // Result with the current digit merged in; zero is taken from this on the
    // last edge so the final digit is included.
    always_comb begin
        o_nxt = o;
        o_nxt[int'(cnt) * D +: D] = dig_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Taking a new op straight from DONE keeps back-to-back ops bubble-free.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            o       <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            a_q     <= i0;
            b_q     <= i1;
            carry_q <= (op == OP_ADD) ? cin : (op == OP_SUB);
            cnt     <= '0;
        end else if (state == ST_BUSY) begin
            o       <= o_nxt;
            carry_q <= dig_co;
            if (last) begin
                cnt  <= '0;
                cout <= is_arith(op_q) && dig_co;
                ovf  <= is_arith(op_q) && (dig_cmsb ^ dig_co);
                zero <= (o_nxt == '0);
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule
